mem_bus_responder: RTL and testbench
====================================

Name: mem_bus_responder

Overview:
Memory-side responder for the CPU memory port: it answers the CPU's address / read-enable / write-enable requests.
- Serves the high-page registers and HRAM internally: HRAM 0xFF80-0xFFFE, IF 0xFF0F, DMA 0xFF46, IE 0xFFFF.
- Forwards every other address to the external memory port.
- Contains the OAM DMA engine: a write to 0xFF46 copies DMA_LEN bytes from {val,8'h00} to OAM_BASE using the external port.
- Sits between the CPU and the sram/cartridge memory.

Parameters:
DMA_LEN, 160, bytes copied per DMA transfer (1..256).
OAM_BASE, 16'hFE00, DMA destination base address.

Ports:
clk  input  1  clock
rst  input  1  reset (asynchronous, active-high)
address  input  16  CPU address, sampled with RE/WE
wdata  input  8  CPU write data
RE  input  1  CPU read request (single cycle)
WE  input  1  CPU write request (single cycle)
rdata  output  8  read data, valid when rvalid
rvalid  output  1  pulses one cycle after an accepted read
dma_active  output  1  high while DMA owns the external port
ext_addr  output  16  external memory address
ext_re  output  1  external read strobe
ext_we  output  1  external write strobe
ext_wdata  output  8  external write data
ext_rdata  input  8  external read data, valid cycle after ext_re

Behaviour:
- Reset (async) values:
  - Outputs: rdata=0, rvalid=0, dma_active=0, ext_re=0, ext_we=0, ext_addr=0, ext_wdata=0.
  - Registers: IF=0, IE=0, DMA reg=0, DMA FSM=IDLE.
  - HRAM contents are undefined after reset.
- Request rules:
  - RE and WE are each single-cycle.
  - RE and WE in the same cycle: WE wins; no rvalid.
- Reads (RE in cycle N): rdata/rvalid valid in cycle N+1, with rvalid high for exactly one cycle.
  - Internal read sources: HRAM array; IF reads {3'b111, IF[4:0]}; IE reads a full 8 bits; 0xFF46 reads the last written value.
  - External reads: ext_addr=address and ext_re=1 combinationally in cycle N; rdata=ext_rdata in cycle N+1.
- Writes (WE in cycle N):
  - Internal registers update at the clock edge ending cycle N; IF stores wdata[4:0].
  - External writes drive ext_we=1, ext_addr, ext_wdata combinationally in cycle N.
- No read-after-write forwarding is needed: a read in cycle N+1 sees the write from cycle N.
- DMA FSM states: IDLE, RD, WR.
  - Write to 0xFF46 with value V: src={V,8'h00}, idx=0, go to RD, dma_active=1 from the next cycle.
  - RD: ext_addr=src+idx, ext_re=1 → WR.
  - WR: ext_addr=OAM_BASE+idx, ext_we=1, ext_wdata=ext_rdata; idx++.
  - From WR: if idx reaches DMA_LEN → IDLE (dma_active drops the next cycle); else → RD.
  - Total transfer time: 2*DMA_LEN cycles.
  - idx and address arithmetic are 16-bit and wrap modulo 2^16 (src FFxx wraps to 0x0000+).
- CPU access while dma_active:
  - HRAM, IF, IE and 0xFF46 remain fully accessible.
  - Any other read returns 0xFF with normal rvalid timing, and the external port is not touched.
  - Any other write is dropped.
- Write to 0xFF46 during DMA: restarts from idx=0 with the new source; the in-flight byte is abandoned and no WR is issued for it.
- Reset mid-DMA: FSM→IDLE immediately; ext strobes deassert asynchronously.
- The external port is never driven by CPU and DMA in the same cycle; DMA has priority.

Test Plan:
- HRAM round trip: WE 0xFF80=0x5A, then RE 0xFF80 → rvalid one cycle later, rdata=0x5A, ext_re/ext_we never asserted.
- IF masking: WE 0xFF0F=0xFF, RE → rdata=0xFF; WE 0x00, RE → rdata=0xE0.
- External forwarding: RE 0xC123 with model returning 0x3C → ext_addr=0xC123 and ext_re in cycle N; rdata=0x3C, rvalid in N+1. WE 0xC000=0x11 → ext_we=1, ext_wdata=0x11.
- Full DMA: preload 0xC000-0xC09F with i^0xA5; WE 0xFF46=0xC0 → dma_active for exactly 320 cycles; 0xFE00+i holds i^0xA5 for all i<160.
- Blocking during DMA: RE 0xC000 → rdata=0xFF, no CPU-driven ext_re; RE 0xFF80 → HRAM value; WE 0xC010 dropped (model unchanged).
- Restart and reset: WE 0xFF46=0xC0, after 50 cycles WE 0xFF46=0xD0 → copy completes from 0xD000 with 320 cycles counted from the restart. A second DMA with rst pulsed mid-transfer → dma_active=0 and ext strobes low immediately; IE=0.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// CPU memory port plus external memory port of the high-page responder.
// The responder takes the slave view; the CPU/memory side takes the master view.
interface mem_bus_responder_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        RE;
    logic        WE;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        dma_active;
    logic [15:0] ext_addr;
    logic        ext_re;
    logic        ext_we;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;

    // Responder side: receives CPU requests and external read data.
    modport slave (
        input  address, wdata, RE, WE, ext_rdata,
        output rdata, rvalid, dma_active, ext_addr, ext_re, ext_we, ext_wdata
    );

    // CPU / memory side: the mirror image of the responder.
    modport master (
        output address, wdata, RE, WE, ext_rdata,
        input  rdata, rvalid, dma_active, ext_addr, ext_re, ext_we, ext_wdata
    );
endinterface

// File: rtl/mem_bus_responder.sv
// High-page responder: serves HRAM, IF, IE and the DMA register locally,
// forwards every other CPU access to the external memory port, and runs the
// OAM DMA engine that copies DMA_LEN bytes from {val,8'h00} into OAM.
module mem_bus_responder #(
    parameter int unsigned DMA_LEN  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00
) (
    input logic                clk,
    input logic                rst,
    mem_bus_responder_if.slave bus
);

    localparam logic [15:0] ADDR_IF  = 16'hFF0F;
    localparam logic [15:0] ADDR_DMA = 16'hFF46;
    localparam logic [15:0] ADDR_IE  = 16'hFFFF;
    localparam logic [15:0] LEN      = 16'(DMA_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } dma_state_e;

    // Decoded CPU request
    logic is_hram, is_if, is_ie, is_dma, is_int;
    logic cpu_rd, cpu_wr, dma_start;

    // CPU-visible storage and read response
    logic [7:0] hram [0:126];
    logic [4:0] if_reg;
    logic [7:0] ie_reg;
    logic [7:0] dma_reg;
    logic [7:0] rdata_q;
    logic       rvalid_q;
    logic       ext_pending;

    // DMA engine
    dma_state_e  state;
    logic [15:0] src;
    logic [15:0] idx;
    logic [15:0] idx_next;
    logic [15:0] dma_addr;
    logic        dma_re;
    logic        dma_we;
    logic        dma_busy;

    assign is_hram   = (bus.address[15:7] == 9'h1FF) && (bus.address != ADDR_IE);
    assign is_if     = (bus.address == ADDR_IF);
    assign is_dma    = (bus.address == ADDR_DMA);
    assign is_ie     = (bus.address == ADDR_IE);
    assign is_int    = is_hram | is_if | is_ie | is_dma;
    assign cpu_wr    = bus.WE;
    assign cpu_rd    = bus.RE & ~bus.WE;   // a simultaneous write wins, no response
    assign dma_start = cpu_wr & is_dma;
    assign idx_next  = idx + 16'd1;

    // Internal registers and the registered read response.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_reg      <= '0;
            ie_reg      <= '0;
            dma_reg     <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            ext_pending <= 1'b0;
        end else begin
            rvalid_q    <= cpu_rd;
            ext_pending <= cpu_rd & ~is_int & ~dma_busy;
            if (cpu_wr) begin
                if (is_if)  if_reg  <= bus.wdata[4:0];
                if (is_ie)  ie_reg  <= bus.wdata;
                if (is_dma) dma_reg <= bus.wdata;
            end
            if (cpu_rd) begin
                if (is_hram)       rdata_q <= hram[bus.address[6:0]];
                else if (is_if)    rdata_q <= {3'b111, if_reg};
                else if (is_ie)    rdata_q <= ie_reg;
                else if (is_dma)   rdata_q <= dma_reg;
                else if (dma_busy) rdata_q <= 8'hFF;   // external space is locked out during DMA
            end
        end
    end

    // HRAM write port.
    // NOTE: HRAM is deliberately left without reset; its contents are undefined until written.
    always_ff @(posedge clk) begin
        if (cpu_wr && is_hram) hram[bus.address[6:0]] <= bus.wdata;
    end

    // OAM DMA engine: alternates RD/WR per byte; a new DMA write restarts it from byte 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            src      <= '0;
            idx      <= '0;
            dma_addr <= '0;
            dma_re   <= 1'b0;
            dma_we   <= 1'b0;
            dma_busy <= 1'b0;
        end else if (dma_start) begin
            state    <= RD;
            src      <= {bus.wdata, 8'h00};
            idx      <= '0;
            dma_addr <= {bus.wdata, 8'h00};
            dma_re   <= 1'b1;
            dma_we   <= 1'b0;
            dma_busy <= 1'b1;
        end else begin
            case (state)
                RD: begin
                    state    <= WR;
                    dma_re   <= 1'b0;
                    dma_we   <= 1'b1;
                    dma_addr <= OAM_BASE + idx;
                end
                WR: begin
                    idx    <= idx_next;
                    dma_we <= 1'b0;
                    if (idx_next == LEN) begin
                        state    <= IDLE;
                        dma_busy <= 1'b0;
                        dma_addr <= '0;
                    end else begin
                        state    <= RD;
                        dma_re   <= 1'b1;
                        dma_addr <= src + idx_next;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // External port mux: DMA owns the port whenever busy, else CPU external accesses pass through.
    // NOTE: every output gets a default first so this block cannot infer latches.
    always_comb begin
        bus.ext_addr  = '0;
        bus.ext_re    = 1'b0;
        bus.ext_we    = 1'b0;
        bus.ext_wdata = '0;
        if (!rst) begin
            if (dma_re) begin
                bus.ext_addr = dma_addr;
                bus.ext_re   = 1'b1;
            end else if (dma_we) begin
                bus.ext_addr  = dma_addr;
                bus.ext_we    = 1'b1;
                bus.ext_wdata = bus.ext_rdata;
            end else if (!dma_busy && !is_int) begin
                if (cpu_wr) begin
                    bus.ext_addr  = bus.address;
                    bus.ext_we    = 1'b1;
                    bus.ext_wdata = bus.wdata;
                end else if (cpu_rd) begin
                    bus.ext_addr = bus.address;
                    bus.ext_re   = 1'b1;
                end
            end
        end
    end

    assign bus.rdata      = ext_pending ? bus.ext_rdata : rdata_q;
    assign bus.rvalid     = rvalid_q;
    assign bus.dma_active = dma_busy;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Self-checking bench for mem_bus_responder: directed register/forwarding
// cases, full and restarted DMA copies, lockout during DMA, reset mid-DMA,
// and a randomized idle-time access mix checked against a behavioural model.
module tb_mem_bus_responder;
    localparam int          DMA_LEN = 160;
    localparam logic [15:0] OAM     = 16'hFE00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_responder_if bus();

    mem_bus_responder #(.DMA_LEN(DMA_LEN), .OAM_BASE(OAM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // External memory model: registered read data, write on strobe, bench pokes.
    logic [7:0]  ext_mem [0:65535];
    bit          mem_ready = 1'b0;
    logic        poke_en;
    logic [15:0] poke_addr;
    logic [7:0]  poke_data;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 65536; a++)
                ext_mem[a] <= (a[15:8] == 8'hC0) ? (a[7:0] ^ 8'hA5) : 8'($urandom);
            mem_ready <= 1'b1;
        end else begin
            if (poke_en)    ext_mem[poke_addr]    <= poke_data;
            if (bus.ext_we) ext_mem[bus.ext_addr] <= bus.ext_wdata;
        end
        if (bus.ext_re) bus.ext_rdata <= ext_mem[bus.ext_addr];
    end

    // Port monitor: DMA cycles carry exactly one strobe; CPU and DMA never overlap.
    int active_cycles = 0;
    int dma_reads     = 0;
    int strobe_bad    = 0;
    always @(negedge clk) begin
        if (bus.dma_active) begin
            active_cycles <= active_cycles + 1;
            if (bus.ext_re == bus.ext_we) strobe_bad <= strobe_bad + 1;
            if (bus.ext_re) dma_reads <= dma_reads + 1;
        end else if (bus.ext_re && bus.ext_we) begin
            strobe_bad <= strobe_bad + 1;
        end
    end

    // Behavioural reference of the internal registers.
    logic [7:0] hram_ref [0:126];
    bit         hram_ok  [0:126];
    logic [4:0] if_ref;
    logic [7:0] ie_ref;
    logic [7:0] dma_ref;
    logic [7:0] exp_oam [0:DMA_LEN-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a != 16'hFFFF);
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [7:0] d);
        if (in_hram(a)) begin
            hram_ref[a - 16'hFF80] = d;
            hram_ok[a - 16'hFF80]  = 1'b1;
        end else if (a == 16'hFF0F) if_ref  = d[4:0];
        else if (a == 16'hFFFF)     ie_ref  = d;
        else if (a == 16'hFF46)     dma_ref = d;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a, input bit busy);
        if (in_hram(a))         return hram_ref[a - 16'hFF80];
        if (a == 16'hFF0F)      return {3'b111, if_ref};
        if (a == 16'hFFFF)      return ie_ref;
        if (a == 16'hFF46)      return dma_ref;
        if (busy)               return 8'hFF;
        return ext_mem[a];
    endfunction

    function automatic void model_reset();
        if_ref  = '0;
        ie_ref  = '0;
        dma_ref = '0;
        for (int i = 0; i < 127; i++) hram_ok[i] = 1'b0;
    endfunction

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    // mode 0: idle internal access (port must stay quiet), 1: forwarded external, 2: port not checked
    task automatic cpu_read(input logic [15:0] a, input logic [7:0] exp, input int mode, input string tag);
        @(posedge clk); #1;
        bus.address = a; bus.RE = 1'b1; bus.WE = 1'b0;
        @(negedge clk);
        check({tag, "_rvlow"}, {31'd0, bus.rvalid}, 0);
        if (mode == 0)      check({tag, "_quiet"}, {30'd0, bus.ext_re, bus.ext_we}, 0);
        else if (mode == 1) check({tag, "_fwd"}, {bus.ext_re, bus.ext_we, bus.ext_addr}, {2'b10, a});
        @(posedge clk); #1;
        bus.RE = 1'b0;
        @(negedge clk);
        check(tag, {bus.rvalid, bus.rdata}, {1'b1, exp});
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input int mode, input string tag);
        @(posedge clk); #1;
        bus.address = a; bus.wdata = d; bus.WE = 1'b1; bus.RE = 1'b0;
        @(negedge clk);
        if (mode == 0)      check({tag, "_quiet"}, {30'd0, bus.ext_re, bus.ext_we}, 0);
        else if (mode == 1) check({tag, "_fwd"}, {bus.ext_re, bus.ext_we, bus.ext_addr, bus.ext_wdata}, {2'b01, a, d});
        @(posedge clk); #1;
        bus.WE = 1'b0;
        model_write(a, d);
    endtask

    task automatic cpu_both(input logic [15:0] a, input logic [7:0] d, input string tag);
        @(posedge clk); #1;
        bus.address = a; bus.wdata = d; bus.RE = 1'b1; bus.WE = 1'b1;
        @(posedge clk); #1;
        bus.RE = 1'b0; bus.WE = 1'b0;
        @(negedge clk);
        check({tag, "_norv"}, {31'd0, bus.rvalid}, 0);
        model_write(a, d);
    endtask

    task automatic wait_dma_idle(input int bound, input string tag);
        int n = 0;
        while (bus.dma_active && n < bound) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, {31'd0, bus.dma_active}, 0);
    endtask

    task automatic check_oam(input string tag);
        for (int i = 0; i < DMA_LEN; i++)
            check(tag, {24'd0, ext_mem[OAM + 16'(i)]}, {24'd0, exp_oam[i]});
    endtask

    task automatic snapshot_src(input logic [7:0] page);
        for (int i = 0; i < DMA_LEN; i++) exp_oam[i] = ext_mem[{page, 8'h00} + 16'(i)];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          start;
        int          reads0;
        int          bad0;
        int unsigned sel;
        int          h;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  saved;

        rst = 1'b1;
        bus.address = '0; bus.wdata = '0; bus.RE = 1'b0; bus.WE = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        model_reset();

        // Reset state
        @(posedge clk); #1;
        check("rst_rdata", {23'd0, bus.rvalid, bus.rdata}, 0);
        check("rst_dma", {31'd0, bus.dma_active}, 0);
        check("rst_ext", {bus.ext_re, bus.ext_we, bus.ext_addr, bus.ext_wdata}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        cpu_read(16'hFF0F, 8'hE0, 0, "rst_if");
        cpu_read(16'hFFFF, 8'h00, 0, "rst_ie");
        cpu_read(16'hFF46, 8'h00, 0, "rst_dmareg");

        // HRAM round trip and its top boundary
        cpu_write(16'hFF80, 8'h5A, 0, "hram_wr");
        cpu_read(16'hFF80, 8'h5A, 0, "hram_rd");
        cpu_write(16'hFFFE, 8'hC3, 0, "hram_top_wr");
        cpu_read(16'hFFFE, 8'hC3, 0, "hram_top_rd");

        // IF masking
        cpu_write(16'hFF0F, 8'hFF, 0, "if_wr_ff");
        cpu_read(16'hFF0F, 8'hFF, 0, "if_rd_ff");
        cpu_write(16'hFF0F, 8'h00, 0, "if_wr_00");
        cpu_read(16'hFF0F, 8'hE0, 0, "if_rd_00");

        // External forwarding
        poke(16'hC123, 8'h3C);
        cpu_read(16'hC123, 8'h3C, 1, "ext_rd");
        cpu_write(16'hC000, 8'h11, 1, "ext_wr");
        check("ext_wr_mem", {24'd0, ext_mem[16'hC000]}, 32'h11);
        poke(16'hC000, 8'hA5);

        // RE and WE together: write wins, no response
        cpu_both(16'hFFFF, 8'h77, "re_we");
        cpu_read(16'hFFFF, 8'h77, 0, "re_we_ie");

        // Full DMA with CPU lockout checks while it runs
        snapshot_src(8'hC0);
        for (int i = 0; i < DMA_LEN; i++) check("preload", {24'd0, exp_oam[i]}, {24'd0, 8'(i) ^ 8'hA5});
        saved  = ext_mem[16'hC010];
        start  = active_cycles;
        reads0 = dma_reads;
        bad0   = strobe_bad;
        cpu_write(16'hFF46, 8'hC0, 0, "dma1_start");
        check("dma1_busy", {31'd0, bus.dma_active}, 1);
        cpu_read(16'hC000, 8'hFF, 2, "lock_rd_c000");
        cpu_read(16'h8123, 8'hFF, 2, "lock_rd_8123");
        cpu_write(16'hFF81, 8'h96, 2, "lock_hram_wr");
        cpu_read(16'hFF81, 8'h96, 2, "lock_hram_rd");
        cpu_read(16'hFF80, 8'h5A, 2, "lock_hram_old");
        cpu_write(16'hC010, 8'h99, 2, "lock_ext_wr");
        cpu_read(16'hFF46, 8'hC0, 2, "lock_dmareg");
        cpu_read(16'hFFFF, model_read(16'hFFFF, 1'b1), 2, "lock_ie");
        wait_dma_idle(1000, "dma1");
        check("dma1_len", active_cycles - start, 2 * DMA_LEN);
        check("dma1_reads", dma_reads - reads0, DMA_LEN);
        check("dma1_strobes", strobe_bad - bad0, 0);
        check("lock_ext_dropped", {24'd0, ext_mem[16'hC010]}, {24'd0, saved});
        check_oam("dma1_oam");

        // Restart mid-transfer from a new page
        snapshot_src(8'hD0);
        cpu_write(16'hFF46, 8'hC0, 0, "dma2_start");
        repeat (50) @(posedge clk);
        bad0 = strobe_bad;
        cpu_write(16'hFF46, 8'hD0, 2, "dma2_restart");
        start = active_cycles;
        wait_dma_idle(1000, "dma2");
        check("dma2_len", active_cycles - start, 2 * DMA_LEN);
        check("dma2_strobes", strobe_bad - bad0, 0);
        check_oam("dma2_oam");
        cpu_read(16'hFF46, 8'hD0, 0, "dma2_reg");

        // Randomized idle-time access mix
        for (int k = 0; k < 80; k++) begin
            sel = $urandom_range(0, 9);
            h   = $urandom_range(0, 126);
            d   = 8'($urandom);
            case (sel)
                0, 1, 2: cpu_write(16'hFF80 + 16'(h), d, 0, "rnd_hram_wr");
                3, 4: begin
                    if (hram_ok[h]) cpu_read(16'hFF80 + 16'(h), model_read(16'hFF80 + 16'(h), 1'b0), 0, "rnd_hram_rd");
                    else            cpu_write(16'hFF80 + 16'(h), d, 0, "rnd_hram_wr");
                end
                5: begin
                    cpu_write(16'hFF0F, d, 0, "rnd_if_wr");
                    cpu_read(16'hFF0F, model_read(16'hFF0F, 1'b0), 0, "rnd_if_rd");
                end
                6: begin
                    cpu_write(16'hFFFF, d, 0, "rnd_ie_wr");
                    cpu_read(16'hFFFF, model_read(16'hFFFF, 1'b0), 0, "rnd_ie_rd");
                end
                7: begin
                    a = 16'($urandom_range(0, 32'hFEFF));
                    cpu_write(a, d, 1, "rnd_ext_wr");
                end
                8: begin
                    a = 16'($urandom_range(0, 32'hFEFF));
                    cpu_read(a, model_read(a, 1'b0), 1, "rnd_ext_rd");
                end
                default: cpu_read(16'hFF46, model_read(16'hFF46, 1'b0), 0, "rnd_dma_rd");
            endcase
        end

        // Reset pulsed mid-DMA
        cpu_write(16'hFFFF, 8'h5A, 0, "pre_rst_ie");
        cpu_write(16'hFF0F, 8'h1F, 0, "pre_rst_if");
        cpu_write(16'hFF46, 8'h20, 0, "dma3_start");
        repeat (37) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid_dma", {29'd0, bus.dma_active, bus.ext_re, bus.ext_we}, 0);
        check("rst_mid_addr", {16'd0, bus.ext_addr}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_dma", {31'd0, bus.dma_active}, 0);
        cpu_read(16'hFFFF, 8'h00, 0, "post_rst_ie");
        cpu_read(16'hFF0F, 8'hE0, 0, "post_rst_if");
        cpu_read(16'hFF46, 8'h00, 0, "post_rst_dmareg");
        cpu_read(16'hC123, model_read(16'hC123, 1'b0), 1, "post_rst_ext");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
